// File: rtl/nine_segment_pkg.sv
// Shared types and the row/column decode for the 3x3 nine-segment matrix.
package nine_segment_pkg;

  localparam int SEG_ROWS = 3;
  localparam int SEG_COLS = 3;

  typedef logic [SEG_ROWS*SEG_COLS-1:0] segment_t;

  typedef enum logic [1:0] {
    PHASE0 = 2'd0,
    PHASE1 = 2'd1,
    PHASE2 = 2'd2
  } phase_t;

  // Rows are active-high selects, columns are active-low drives.
  function automatic segment_t lit_mask(input logic [SEG_ROWS-1:0] rows,
                                        input logic [SEG_COLS-1:0] cols);
    segment_t mask;
    mask = '0;
    for (int r = 0; r < SEG_ROWS; r++) begin
      for (int c = 0; c < SEG_COLS; c++) begin
        mask[r*SEG_COLS+c] = rows[r] & ~cols[c];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/nine_segment_stability_filter.sv
// Qualifies a stream of completed frames: asserts stable once the same frame
// has been seen STABLE_FRAMES times in a row and captures that frame.
module nine_segment_stability_filter
  import nine_segment_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     frame_valid_i,
  input  segment_t frame_i,
  output logic     stable_o,
  output segment_t stable_segments_o
);

  localparam logic [3:0] THRESHOLD = 4'(STABLE_FRAMES);

  segment_t   prev_q, prev_d;
  segment_t   stable_seg_q, stable_seg_d;
  logic [3:0] count_q, count_d;

  always_comb begin
    prev_d       = prev_q;
    count_d      = count_q;
    stable_seg_d = stable_seg_q;
    if (frame_valid_i) begin
      prev_d = frame_i;
      // A zero count means no frame has been seen since reset.
      if (count_q != 4'd0 && frame_i == prev_q) begin
        count_d = (count_q >= THRESHOLD) ? THRESHOLD : count_q + 4'd1;
      end else begin
        count_d = 4'd1;
      end
      if (count_d >= THRESHOLD) begin
        stable_seg_d = frame_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q       <= '0;
      count_q      <= '0;
      stable_seg_q <= '0;
    end else begin
      prev_q       <= prev_d;
      count_q      <= count_d;
      stable_seg_q <= stable_seg_d;
    end
  end

  assign stable_o          = (count_q >= THRESHOLD);
  assign stable_segments_o = stable_seg_q;

endmodule

// File: rtl/six_pin_to_nine_segment.sv
// Rebuilds 9-bit segment frames from the scanned 3-row/3-column drive pins,
// one enabled sample per phase, and feeds completed frames to a stability filter.
module six_pin_to_nine_segment
  import nine_segment_pkg::*;
#(
  parameter int STABLE_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sync,
  input  logic [SEG_ROWS-1:0] rows,
  input  logic [SEG_COLS-1:0] cols,
  output segment_t            segments,
  output logic                frame_valid,
  output logic                stable,
  output segment_t            stable_segments
);

  phase_t   phase_q, phase_d, cur_phase;
  segment_t acc_q, acc_d;
  segment_t seg_q, seg_d;
  logic     frame_valid_q, frame_valid_d;
  segment_t mask;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    phase_d       = phase_q;
    acc_d         = acc_q;
    seg_d         = seg_q;
    frame_valid_d = 1'b0;
    mask          = lit_mask(rows, cols);
    // sync forces phase 0, dropping whatever partial frame was accumulating.
    cur_phase     = sync ? PHASE0 : phase_q;
    if (enable) begin
      case (cur_phase)
        PHASE0: begin
          acc_d   = mask;
          phase_d = PHASE1;
        end
        PHASE1: begin
          acc_d   = acc_q | mask;
          phase_d = PHASE2;
        end
        PHASE2: begin
          seg_d         = acc_q | mask;
          frame_valid_d = 1'b1;
          phase_d       = PHASE0;
        end
        default: phase_d = PHASE0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= PHASE0;
      acc_q         <= '0;
      seg_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      acc_q         <= acc_d;
      seg_q         <= seg_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Fed from next-state so stability updates on the same edge as segments.
  nine_segment_stability_filter #(
    .STABLE_FRAMES(STABLE_FRAMES)
  ) u_filter (
    .clk              (clk),
    .reset            (reset),
    .frame_valid_i    (frame_valid_d),
    .frame_i          (seg_d),
    .stable_o         (stable),
    .stable_segments_o(stable_segments)
  );

  assign segments    = seg_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_six_pin_to_nine_segment.sv
// Directed self-checking bench for six_pin_to_nine_segment with STABLE_FRAMES=2.
module tb_six_pin_to_nine_segment;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sync;
  logic [2:0] rows;
  logic [2:0] cols;
  logic [8:0] segments;
  logic       frame_valid;
  logic       stable;
  logic [8:0] stable_segments;

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [8:0] FRAME_A = 9'b100010001;
  localparam logic [8:0] FRAME_B = 9'b111000111;

  six_pin_to_nine_segment #(.STABLE_FRAMES(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .sync           (sync),
    .rows           (rows),
    .cols           (cols),
    .segments       (segments),
    .frame_valid    (frame_valid),
    .stable         (stable),
    .stable_segments(stable_segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [8:0] seg, input logic fv,
                           input logic st, input logic [8:0] sseg);
    check({tag, ".segments"}, 16'(segments), 16'(seg));
    check({tag, ".frame_valid"}, 16'(frame_valid), 16'(fv));
    check({tag, ".stable"}, 16'(stable), 16'(st));
    check({tag, ".stable_segments"}, 16'(stable_segments), 16'(sseg));
  endtask

  // One enabled sample; returns 1ns after the sampling edge.
  task automatic send(input logic s, input logic [2:0] r, input logic [2:0] c);
    @(negedge clk);
    enable = 1'b1;
    sync   = s;
    rows   = r;
    cols   = c;
    @(posedge clk);
    #1;
    enable = 1'b0;
    sync   = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame_a(input logic s);
    send(s, 3'b100, 3'b011);
    send(1'b0, 3'b010, 3'b101);
    send(1'b0, 3'b001, 3'b110);
  endtask

  task automatic send_frame_b();
    for (int i = 0; i < 3; i++) send(1'b0, 3'b101, 3'b000);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    sync   = 1'b0;
    rows   = 3'b000;
    cols   = 3'b111;
    repeat (3) idle();
    check_out("in_reset", 9'd0, 1'b0, 1'b0, 9'd0);
    reset = 1'b0;
    idle();
    check_out("after_reset", 9'd0, 1'b0, 1'b0, 9'd0);

    // Dark pins with enable toggling: one all-zero frame.
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 3'b000, 3'b111);
      idle();
    end
    check("dark.segments", 16'(segments), 16'd0);
    check("dark.stable", 16'(stable), 16'd0);

    // Diagonal frame with sync on the first sample.
    send(1'b1, 3'b100, 3'b011);
    send(1'b0, 3'b010, 3'b101);
    check("diag.early_fv", 16'(frame_valid), 16'd0);
    send(1'b0, 3'b001, 3'b110);
    check_out("diag", FRAME_A, 1'b1, 1'b0, 9'd0);
    idle();
    check("diag.fv_one_cycle", 16'(frame_valid), 16'd0);

    // Multi-row / multi-column samples.
    for (int i = 0; i < 3; i++) send(1'b0, 3'b101, 3'b010);
    check_out("corners", 9'b101000101, 1'b1, 1'b0, 9'd0);

    // Dark middle phase.
    send(1'b0, 3'b100, 3'b011);
    send(1'b0, 3'b000, 3'b000);
    send(1'b0, 3'b001, 3'b110);
    check_out("dark_phase", 9'b100000001, 1'b1, 1'b0, 9'd0);

    // Abort: sync lands in the PHASE2 slot and must not complete a frame.
    send(1'b0, 3'b100, 3'b011);
    check("abort.fv1", 16'(frame_valid), 16'd0);
    send(1'b0, 3'b010, 3'b101);
    check("abort.fv2", 16'(frame_valid), 16'd0);
    send(1'b1, 3'b010, 3'b101);
    check("abort.fv_sync", 16'(frame_valid), 16'd0);
    check("abort.seg_held", 16'(segments), 16'(9'b100000001));
    send(1'b0, 3'b000, 3'b111);
    check("abort.fv4", 16'(frame_valid), 16'd0);
    send(1'b0, 3'b000, 3'b111);
    check_out("abort.next", 9'b000010000, 1'b1, 1'b0, 9'd0);

    // Stability: A, A, B, B, B.
    send_frame_a(1'b0);
    check_out("stab.A1", FRAME_A, 1'b1, 1'b0, 9'd0);
    send_frame_a(1'b0);
    check_out("stab.A2", FRAME_A, 1'b1, 1'b1, FRAME_A);
    send_frame_b();
    check_out("stab.B1", FRAME_B, 1'b1, 1'b0, FRAME_A);
    send_frame_b();
    check_out("stab.B2", FRAME_B, 1'b1, 1'b1, FRAME_B);
    send_frame_b();
    check_out("stab.B3", FRAME_B, 1'b1, 1'b1, FRAME_B);
    idle();
    check("stab.hold_stable", 16'(stable), 16'd1);

    // Asynchronous reset between PHASE1 and PHASE2.
    send(1'b1, 3'b100, 3'b011);
    send(1'b0, 3'b010, 3'b101);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset", 9'd0, 1'b0, 1'b0, 9'd0);
    @(negedge clk);
    reset = 1'b0;
    send_frame_a(1'b0);
    check_out("post_reset", FRAME_A, 1'b1, 1'b0, 9'd0);
    idle();
    check("post_reset.fv_low", 16'(frame_valid), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
